fu_alu_scheduler: RTL and testbench

//  - Shares the single-cycle combinational ALU functional unit between N_REQ issue requesters.
//  - Round-robin arbiter drives the ALU operands, then registers the result, flags, tag and

---
 rtl/fu_alu_scheduler.sv | 134 +++++++++++++
 tb/tb_fu_alu_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fu_alu_scheduler.sv
// Round-robin share of one combinational ALU among N_REQ requesters; optional perf counters via FU_ALU_SCHED_PERF_EN.
// Latency: 1 cycle from request handshake to wb_valid with the registered result.
// Backpressure: the one-entry result stage drains on wb_ready; when full and stalled, all req_ready are low.
module fu_alu_scheduler #(
  parameter int N_REQ = 4,
  parameter int TAG_W = 6,
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*4-1:0]     req_aluop,
  input  logic [N_REQ*32-1:0]    req_a,
  input  logic [N_REQ*32-1:0]    req_b,
  input  logic [N_REQ*TAG_W-1:0] req_tag,
  input  logic                   flush,
  output logic [3:0]             alu_aluop,
  output logic [31:0]            alu_port_a,
  output logic [31:0]            alu_port_b,
  input  logic [31:0]            alu_port_output,
  input  logic                   alu_negative,
  input  logic                   alu_overflow,
  input  logic                   alu_zero,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [31:0]            wb_data,
  output logic [2:0]             wb_flags,
  output logic [TAG_W-1:0]       wb_tag,
`ifdef FU_ALU_SCHED_PERF_EN
  output logic [31:0]            perf_issue_cnt,
  output logic [31:0]            perf_stall_cnt,
`endif
  output logic [SRC_W-1:0]       wb_src
);

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [31:0]      data;
    logic [2:0]       flags;
    logic [TAG_W-1:0] tag;
    logic [SRC_W-1:0] src;
  } wb_t;

  state_t           state_q, state_d;
  wb_t              wb_q;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] grant;
  logic             any_vld;
  logic             can_issue;
  logic             issue;
  int               idx;

  // Search from rr_ptr upward, wrapping; the first valid slot wins.
  always_comb begin
    grant   = '0;
    any_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_vld && req_valid[idx]) begin
        grant   = SRC_W'(idx);
        any_vld = 1'b1;
      end
    end
  end

  assign can_issue = !flush && (state_q == EMPTY || wb_ready);
  assign issue     = can_issue && any_vld;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[grant] = 1'b1;
  end

  always_comb begin
    alu_aluop  = '0;
    alu_port_a = '0;
    alu_port_b = '0;
    if (any_vld) begin
      alu_aluop  = req_aluop[int'(grant)*4 +: 4];
      alu_port_a = req_a[int'(grant)*32 +: 32];
      alu_port_b = req_b[int'(grant)*32 +: 32];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Flush wins; a drain with no refill frees the slot.
  always_comb begin
    state_d = state_q;
    if (flush)                             state_d = EMPTY;
    else if (issue)                        state_d = FULL;
    else if (state_q == FULL && wb_ready)  state_d = EMPTY;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_q   <= '0;
      rr_ptr <= '0;
    end else if (issue) begin
      wb_q.data  <= alu_port_output;
      wb_q.flags <= {alu_negative, alu_overflow, alu_zero};
      wb_q.tag   <= req_tag[int'(grant)*TAG_W +: TAG_W];
      wb_q.src   <= grant;
      if (N_REQ == 1 || int'(grant) == N_REQ - 1) rr_ptr <= '0;
      else                                         rr_ptr <= grant + SRC_W'(1);
    end
  end

  assign wb_valid = (state_q == FULL);
  assign wb_data  = wb_q.data;
  assign wb_flags = wb_q.flags;
  assign wb_tag   = wb_q.tag;
  assign wb_src   = wb_q.src;

`ifdef FU_ALU_SCHED_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue)                 perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (any_vld && !can_issue) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fu_alu_scheduler.sv
// Directed bench for fu_alu_scheduler with a small behavioural ALU on the alu_* side.
// Perf counter checks are compiled in when FU_ALU_SCHED_PERF_EN is defined.
module tb_fu_alu_scheduler;

  localparam int N_REQ = 4;
  localparam int TAG_W = 6;
  localparam int SRC_W = 2;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;

  logic                   CLK = 1'b0;
  logic                   RST;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*4-1:0]     req_aluop;
  logic [N_REQ*32-1:0]    req_a;
  logic [N_REQ*32-1:0]    req_b;
  logic [N_REQ*TAG_W-1:0] req_tag;
  logic                   flush;
  logic [3:0]             alu_aluop;
  logic [31:0]            alu_port_a;
  logic [31:0]            alu_port_b;
  logic [31:0]            alu_port_output;
  logic                   alu_negative;
  logic                   alu_overflow;
  logic                   alu_zero;
  logic                   wb_valid;
  logic                   wb_ready;
  logic [31:0]            wb_data;
  logic [2:0]             wb_flags;
  logic [TAG_W-1:0]       wb_tag;
  logic [SRC_W-1:0]       wb_src;
`ifdef FU_ALU_SCHED_PERF_EN
  logic [31:0]            perf_issue_cnt;
  logic [31:0]            perf_stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  fu_alu_scheduler #(.N_REQ(N_REQ), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .flush(flush),
    .alu_aluop(alu_aluop), .alu_port_a(alu_port_a), .alu_port_b(alu_port_b),
    .alu_port_output(alu_port_output),
    .alu_negative(alu_negative), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_flags(wb_flags), .wb_tag(wb_tag),
`ifdef FU_ALU_SCHED_PERF_EN
    .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .wb_src(wb_src)
  );

  // Behavioural ALU: add/sub with N/V/Z flags, everything else yields zero.
  always_comb begin
    alu_port_output = '0;
    alu_overflow    = 1'b0;
    case (alu_aluop)
      OP_ADD: begin
        alu_port_output = alu_port_a + alu_port_b;
        alu_overflow = (alu_port_a[31] == alu_port_b[31]) && (alu_port_output[31] != alu_port_a[31]);
      end
      OP_SUB: begin
        alu_port_output = alu_port_a - alu_port_b;
        alu_overflow = (alu_port_a[31] != alu_port_b[31]) && (alu_port_output[31] != alu_port_a[31]);
      end
      default: alu_port_output = '0;
    endcase
    alu_negative = alu_port_output[31];
    alu_zero     = (alu_port_output == 32'd0);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] tag);
    req_aluop[i*4 +: 4]         = op;
    req_a[i*32 +: 32]           = a;
    req_b[i*32 +: 32]           = b;
    req_tag[i*TAG_W +: TAG_W]   = tag;
  endtask

  logic [3:0] exp_rdy;
  int         g;

  initial begin
    RST = 1'b1; req_valid = '0; req_aluop = '0; req_a = '0; req_b = '0;
    req_tag = '0; flush = 1'b0; wb_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_flags", wb_flags, 0);
    check("rst_wb_tag", wb_tag, 0);
    check("rst_wb_src", wb_src, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_alu_aluop", alu_aluop, 0);
    check("rst_alu_a", alu_port_a, 0);
    check("rst_alu_b", alu_port_b, 0);
`ifdef FU_ALU_SCHED_PERF_EN
    check("rst_perf_issue", perf_issue_cnt, 0);
    check("rst_perf_stall", perf_stall_cnt, 0);
`endif
    RST = 1'b0;

    // Single ADD from slot 1
    set_slot(1, OP_ADD, 32'd5, 32'd7, 6'd9);
    req_valid = 4'b0010; wb_ready = 1'b1;
    #1;
    check("add_req_ready", req_ready, 4'b0010);
    check("add_alu_a", alu_port_a, 5);
    check("add_alu_b", alu_port_b, 7);
    tick();
    req_valid = '0;
    check("add_wb_valid", wb_valid, 1);
    check("add_wb_data", wb_data, 12);
    check("add_wb_flags", wb_flags, 3'b000);
    check("add_wb_tag", wb_tag, 9);
    check("add_wb_src", wb_src, 1);

    // Negative and zero flags; rr_ptr walks 2 -> 3 -> 0
    set_slot(2, OP_SUB, 32'd3, 32'd5, 6'd5);
    req_valid = 4'b0100;
    #1 check("sub_req_ready", req_ready, 4'b0100);
    tick();
    check("sub_wb_data", wb_data, 32'hFFFF_FFFE);
    check("sub_wb_flags", wb_flags, 3'b100);
    check("sub_wb_src", wb_src, 2);
    set_slot(3, OP_SUB, 32'd7, 32'd7, 6'd63);
    req_valid = 4'b1000;
    tick();
    check("zero_wb_data", wb_data, 0);
    check("zero_wb_flags", wb_flags, 3'b001);
    check("zero_wb_tag", wb_tag, 63);

    // All requesters valid: grants 0,1,2,3,0 back to back
    for (int i = 0; i < N_REQ; i++) set_slot(i, OP_ADD, 32'(i*10 + 1), 32'd1, 6'(20 + i));
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      exp_rdy = 4'b0001 << g;
      #1 check("rr_req_ready", req_ready, exp_rdy);
      tick();
      check("rr_wb_valid", wb_valid, 1);
      check("rr_wb_src", wb_src, g);
      check("rr_wb_data", wb_data, g*10 + 2);
      check("rr_wb_tag", wb_tag, 20 + g);
    end

    // Backpressure for 3 cycles, then same-cycle grant on release
    wb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_req_ready", req_ready, 0);
      check("bp_wb_data", wb_data, 2);
      check("bp_wb_valid", wb_valid, 1);
      tick();
    end
    wb_ready = 1'b1;
    #1 check("bp_release_ready", req_ready, 4'b0010);
    tick();
    check("bp_release_src", wb_src, 1);
    check("bp_release_data", wb_data, 12);

    // Flush while full: no grant, slot emptied, rr_ptr stays at 2
    flush = 1'b1; req_valid = 4'b0001;
    #1 check("flush_req_ready", req_ready, 0);
    tick();
    flush = 1'b0; req_valid = '0;
    #1 check("flush_wb_valid", wb_valid, 0);
    req_valid = 4'b1111;
    #1 check("flush_rr_kept", req_ready, 4'b0100);
    tick();
    check("post_flush_src", wb_src, 2);

    // Wrap: rr_ptr=3, only slot 0 valid
    req_valid = 4'b0001;
    #1 check("wrap_req_ready", req_ready, 4'b0001);
    tick();
    check("wrap_wb_src", wb_src, 0);

    // Reset while full discards the result
    req_valid = '0; RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst_full_wb_valid", wb_valid, 0);
    check("rst_full_wb_data", wb_data, 0);
    check("rst_full_wb_src", wb_src, 0);

`ifdef FU_ALU_SCHED_PERF_EN
    // 5 issues then 2 stalled cycles; flush clears both counters
    req_valid = 4'b0001; wb_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    wb_ready = 1'b0;
    tick(); tick();
    req_valid = '0;
    #1;
    check("perf_issue", perf_issue_cnt, 5);
    check("perf_stall", perf_stall_cnt, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("perf_issue_flush", perf_issue_cnt, 0);
    check("perf_stall_flush", perf_stall_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
